// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer: FSM states, default width
// and the bit-counter width helper.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int SER_WIDTH_DEF = 19;

    // Counter must be able to hold the value WIDTH itself (one past the last beat).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/word_serializer_shreg.sv
// WIDTH-bit right-shift register with synchronous clear, parallel load and
// shift enable; load wins over shift, zeros are shifted in at the MSB.
module word_serializer_shreg #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shift_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign shift_next[gi] = 1'b0;
            end else begin : g_body
                assign shift_next[gi] = q_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_data;
        end else if (shift_en) begin
            q_reg <= shift_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/word_serializer.sv
// Parallel-in, LSB-first serial-out transmitter with first/last framing strobes.
// Define PARITY_EN to append an even-parity beat after the last data bit.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] shreg_q;
    logic             load;
    logic             shift_en;

    // Capture only happens from IDLE, so in_data is ignored while a frame is in flight.
    assign load     = (state_reg == IDLE) && in_valid;
    assign shift_en = (state_reg == SHIFT) && ser_ready;

    word_serializer_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .shift_en (shift_en),
        .load_data(in_data),
        .q        (shreg_q)
    );

`ifdef PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            parity_reg <= 1'b0;
        end else if (load) begin
            parity_reg <= ^in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_first  = 1'b0;
        ser_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                    count_next = '0;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[0];
                ser_first = (count_reg == '0);
`ifndef PARITY_EN
                ser_last  = (count_reg == LAST_CNT);
`endif
                if (ser_ready) begin
                    count_next = count_reg + CNT_W'(1);
                    if (count_reg == LAST_CNT) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = parity_reg;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);

endmodule
